// File: rtl/coffee_dispense_ctrl_pkg.sv
// Shared types for the coffee vending transaction path: coin encodings,
// coin values in cents and the controller state enum.
package coffee_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2,
    COIN_BAD  = 2'd3
  } coin_t;

  localparam logic [4:0] CENTS_5  = 5'd5;
  localparam logic [4:0] CENTS_10 = 5'd10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CUP     = 3'd2,
    BREW    = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic coin_valid(input logic [1:0] c);
    return (c == COIN_5) || (c == COIN_10);
  endfunction

  function automatic logic [4:0] coin_cents(input logic [1:0] c);
    case (c)
      COIN_5:  return CENTS_5;
      COIN_10: return CENTS_10;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coffee_dispense_ctrl_if.sv
// Coin-slot and actuator bundle between the coin acceptors, the controller
// and the cup/brew actuators.
interface coffee_dispense_ctrl_if;
  // A coin is offered in any cycle where coins_x is nonzero and is credited
  // in that same cycle unless coin_reject_x is high; there is no back-pressure,
  // a rejected coin is simply returned by the acceptor.
  logic [1:0] coins_a;
  logic [1:0] coins_b;
  logic       coin_reject_a;
  logic       coin_reject_b;
  logic       grant_a;
  logic       grant_b;
  logic       busy;
  logic       cup_drop;
  logic       brew_on;
  logic       coffee_done;
  logic       change_valid;
  logic [4:0] change_cents;

  modport master (
    output coins_a, coins_b,
    input  coin_reject_a, coin_reject_b, grant_a, grant_b, busy,
    input  cup_drop, brew_on, coffee_done, change_valid, change_cents
  );

  modport slave (
    input  coins_a, coins_b,
    output coin_reject_a, coin_reject_b, grant_a, grant_b, busy,
    output cup_drop, brew_on, coffee_done, change_valid, change_cents
  );
endinterface

// File: rtl/coffee_dispense_ctrl_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
// Shared by the collect timeout, the cup phase and the brew phase.
module coffee_cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/coffee_dispense_ctrl.sv
// Round-robin two-slot coin collector that sequences cup drop and brew,
// returns change, and refunds a stalled customer after a timeout.
module coffee_dispense_ctrl
  import coffee_pkg::*;
#(
  parameter int PRICE_CENTS    = 15,
  parameter int CUP_CYCLES     = 4,
  parameter int BREW_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  coffee_dispense_ctrl_if.slave  io_bus,
  output state_t                 o_state
);
  localparam int T_CB  = (CUP_CYCLES > BREW_CYCLES) ? CUP_CYCLES : BREW_CYCLES;
  localparam int T_MAX = (TIMEOUT_CYCLES > T_CB) ? TIMEOUT_CYCLES : T_CB;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [4:0]    PRICE      = 5'(PRICE_CENTS);
  localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LD_CUP     = TW'(CUP_CYCLES - 1);
  localparam logic [TW-1:0] LD_BREW    = TW'(BREW_CYCLES - 1);

  state_t     r_state;
  logic       r_rr_b;
  logic [4:0] r_credit;
  logic       r_grant_a, r_grant_b, r_busy;
  logic       r_cup_drop, r_brew_on, r_coffee_done;
  logic       r_change_valid;
  logic [4:0] r_change_cents;

  logic       w_va, w_vb, w_a_wins, w_b_wins, w_own_ok;
  logic [4:0] w_win_cents, w_sum;
  logic       w_tmr_load, w_tmr_done;
  logic [TW-1:0] w_tmr_val;

  assign w_va = coin_valid(io_bus.coins_a);
  assign w_vb = coin_valid(io_bus.coins_b);

  // In IDLE a lone valid coin wins outright; on a tie the pointer decides.
  assign w_a_wins = (r_state == IDLE) && w_va && (!w_vb || !r_rr_b);
  assign w_b_wins = (r_state == IDLE) && w_vb && (!w_va || r_rr_b);
  assign w_win_cents = w_a_wins ? coin_cents(io_bus.coins_a) : coin_cents(io_bus.coins_b);

  assign w_own_ok = (r_state == COLLECT) && ((r_grant_a && w_va) || (r_grant_b && w_vb));
  assign w_sum    = r_credit + (r_grant_a ? coin_cents(io_bus.coins_a) : coin_cents(io_bus.coins_b));

  // Any present coin that is not credited this cycle goes back to the customer.
  assign io_bus.coin_reject_a = (io_bus.coins_a != COIN_NONE) &&
                                !(w_a_wins || (w_own_ok && r_grant_a));
  assign io_bus.coin_reject_b = (io_bus.coins_b != COIN_NONE) &&
                                !(w_b_wins || (w_own_ok && r_grant_b));

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = LD_TIMEOUT;
    case (r_state)
      IDLE: if (w_a_wins || w_b_wins) begin
        w_tmr_load = 1'b1;
        if (w_win_cents >= PRICE) w_tmr_val = LD_CUP;
      end
      COLLECT: if (w_own_ok) begin
        w_tmr_load = 1'b1;
        if (w_sum >= PRICE) w_tmr_val = LD_CUP;
      end
      CUP: if (w_tmr_done) begin
        w_tmr_load = 1'b1;
        w_tmr_val  = LD_BREW;
      end
      default: ;
    endcase
  end

  coffee_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rr_b         <= 1'b0;
      r_credit       <= '0;
      r_grant_a      <= 1'b0;
      r_grant_b      <= 1'b0;
      r_busy         <= 1'b0;
      r_cup_drop     <= 1'b0;
      r_brew_on      <= 1'b0;
      r_coffee_done  <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_cents <= '0;
    end else begin
      r_change_valid <= 1'b0;
      r_change_cents <= '0;
      r_coffee_done  <= 1'b0;
      case (r_state)
        IDLE: if (w_a_wins || w_b_wins) begin
          r_grant_a <= w_a_wins;
          r_grant_b <= w_b_wins;
          r_busy    <= 1'b1;
          r_credit  <= w_win_cents;
          if (w_win_cents >= PRICE) begin
            r_state        <= CUP;
            r_cup_drop     <= 1'b1;
            r_change_valid <= (w_win_cents != PRICE);
            r_change_cents <= w_win_cents - PRICE;
          end else begin
            r_state <= COLLECT;
          end
        end
        COLLECT: if (w_own_ok) begin
          r_credit <= w_sum;
          if (w_sum >= PRICE) begin
            r_state        <= CUP;
            r_cup_drop     <= 1'b1;
            r_change_valid <= (w_sum != PRICE);
            r_change_cents <= w_sum - PRICE;
          end
        end else if (w_tmr_done) begin
          r_state        <= IDLE;
          r_change_valid <= 1'b1;
          r_change_cents <= r_credit;
          r_credit       <= '0;
          r_grant_a      <= 1'b0;
          r_grant_b      <= 1'b0;
          r_busy         <= 1'b0;
          r_rr_b         <= !r_rr_b;
        end
        CUP: if (w_tmr_done) begin
          r_state    <= BREW;
          r_cup_drop <= 1'b0;
          r_brew_on  <= 1'b1;
        end
        BREW: if (w_tmr_done) begin
          r_state       <= DONE;
          r_brew_on     <= 1'b0;
          r_coffee_done <= 1'b1;
        end
        DONE: begin
          r_state   <= IDLE;
          r_credit  <= '0;
          r_grant_a <= 1'b0;
          r_grant_b <= 1'b0;
          r_busy    <= 1'b0;
          r_rr_b    <= !r_rr_b;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.grant_a      = r_grant_a;
  assign io_bus.grant_b      = r_grant_b;
  assign io_bus.busy         = r_busy;
  assign io_bus.cup_drop     = r_cup_drop;
  assign io_bus.brew_on      = r_brew_on;
  assign io_bus.coffee_done  = r_coffee_done;
  assign io_bus.change_valid = r_change_valid;
  assign io_bus.change_cents = r_change_cents;
  assign o_state             = r_state;
endmodule
